alu_status_reg: RTL and testbench
=================================

// Module: alu_status_reg
// PURPOSE
//  Sequential status register for the ALU's combinational flag output (alu_status_t).
//  - Latches flags after an ALU op; supports bus load and tri-state bus readback.
//  - Evaluates 4-bit branch/predication condition codes against the latched flags.
//  - Keeps a small LIFO save stack for interrupt entry/return.
// PARAMETERS
//  WIDTH        32  data bus width; status occupies bits [3:0], upper bits read 0
//  STACK_DEPTH  4   save-stack entries (>=1)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  alu_status  in   alu_status_t  flags from ALU (carry, overflow, negative, zero)
//  status_ld   in   1      latch alu_status at next edge
//  bus_in      in   WIDTH  data for bus_ld; bits [3:0] = {V,C,N,Z}
//  bus_ld      in   1      load status from bus_in[3:0]
//  bus_oe      in   1      drive status onto bus_out
//  bus_out     out  WIDTH  tri; {'0,V,C,N,Z} when bus_oe else 'z
//  push        in   1      save current status to stack
//  pop         in   1      restore status from stack top
//  err_clr     in   1      clear sticky stack_err
//  cond        in   cond_e (4)  condition code to evaluate
//  cond_true   out  1      comb.; cond holds on registered flags
//  stack_empty out  1      sp == 0
//  stack_full  out  1      sp == STACK_DEPTH
//  stack_err   out  1      sticky overflow/underflow flag
// BEHAVIOUR
//  Reset (async, any time, incl. mid-push/pop): flags=0, sp=0, stack_err=0;
//   stack contents don't care; bus_out per bus_oe (drives 0 if oe).
//  Register update priority per edge: pop > bus_ld > status_ld; else hold.
//  Latency: loads/pops visible on flags, bus_out, cond_true 1 cycle after edge.
//  cond_true, bus_out are combinational from registered state; never from alu_status.
//  push: stores pre-edge flags at stack[sp], sp++. Same-edge status_ld/bus_ld still
//   update flags (stack gets old value).
//  pop: flags <= stack[sp-1], sp--.
//  push & pop same edge: stack, sp, flags unchanged (both ignored), no error.
//  push when full: dropped, sp held, stack_err<=1. Pop when empty: flags held
//   (lower-priority bus_ld/status_ld still apply), stack_err<=1.
//  err_clr clears stack_err; a new error on the same edge wins (set).
//  Conditions (cond_e): 0 AL=1; 1 EQ=Z; 2 NE=!Z; 3 MI=N; 4 PL=!N; 5 VS=V; 6 VC=!V;
//   7 CS=C; 8 CC=!C; 9 HI=C&!Z; 10 LS=!C|Z; 11 LT=N^V; 12 GE=!(N^V);
//   13 GT=!Z&!(N^V); 14 LE=Z|(N^V); 15 NV=0.
// CONFIGURATION
//  ALU_STATUS_STACK_EN defined: save stack as above.
//  Undefined: no stack storage; push/pop ignored; stack_empty=1, stack_full=1,
//   stack_err=0 constant; err_clr ignored.
// STRUCTURE
//  alu_pkg: cond_e enum (above), STATUS_BITS=4 and bus bit positions
//   (Z=0,N=1,C=2,V=3), alongside alu_status_t.
//  Sub-module cond_eval: combinational (alu_status_t, cond_e) -> cond_true.
//  Stack as register array + sp counter [$clog2(STACK_DEPTH+1)-1:0].
// TESTING
//  1 rst pulse -> bus_out(oe)=0x0, AL=1, EQ=0, NE=1, NV=0, empty=1, err=0.
//  2 status_ld with Z=1 -> next cycle EQ=1, LE=1, GT=0, HI=0.
//  3 ld N=1,V=0 -> LT=1,GE=0; ld N=1,V=1 -> GE=1,LT=0; ld C=1,Z=0 -> HI=1,LS=0.
//  4 bus_ld 0xFFFF_FFFF, then bus_oe=1 -> 0x0000_000F; bus_oe=0 -> all z.
//  5 push 0x1,0x2,0x4,0x8 -> full; 5th push -> err=1, sp=4; 4 pops -> 0x8,0x4,0x2,0x1;
//    5th pop -> err=1, flags stay 0x1; err_clr -> err=0.
//  6 flags=0x3; push+status_ld(0xC) same edge -> flags 0xC; pop -> 0x3.
//    push+pop same edge -> sp, flags unchanged, err=0.
//    rst asserted mid-sequence -> immediate clear.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU status register: flag struct, condition codes, bus layout.
package alu_pkg;

  localparam int STATUS_BITS = 4;
  localparam int BIT_Z = 0;
  localparam int BIT_N = 1;
  localparam int BIT_C = 2;
  localparam int BIT_V = 3;

  // Field order matches the bus nibble {V,C,N,Z}, so a packed cast maps directly.
  typedef struct packed {
    logic overflow;
    logic carry;
    logic negative;
    logic zero;
  } alu_status_t;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_MI = 4'd3,
    COND_PL = 4'd4,
    COND_VS = 4'd5,
    COND_VC = 4'd6,
    COND_CS = 4'd7,
    COND_CC = 4'd8,
    COND_HI = 4'd9,
    COND_LS = 4'd10,
    COND_LT = 4'd11,
    COND_GE = 4'd12,
    COND_GT = 4'd13,
    COND_LE = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/alu_status_reg_cond_eval.sv
// Combinational condition-code evaluator: decides whether cond holds on a set of flags.
module cond_eval
  import alu_pkg::*;
(
  input  alu_status_t i_flags,
  input  cond_e       i_cond,
  output logic        o_true
);

  logic w_lt;
  assign w_lt = i_flags.negative ^ i_flags.overflow;

  // NOTE: assign a default before the case so no path leaves o_true unassigned (no latch).
  always_comb begin
    o_true = 1'b0;
    case (i_cond)
      COND_AL: o_true = 1'b1;
      COND_EQ: o_true = i_flags.zero;
      COND_NE: o_true = !i_flags.zero;
      COND_MI: o_true = i_flags.negative;
      COND_PL: o_true = !i_flags.negative;
      COND_VS: o_true = i_flags.overflow;
      COND_VC: o_true = !i_flags.overflow;
      COND_CS: o_true = i_flags.carry;
      COND_CC: o_true = !i_flags.carry;
      COND_HI: o_true = i_flags.carry && !i_flags.zero;
      COND_LS: o_true = !i_flags.carry || i_flags.zero;
      COND_LT: o_true = w_lt;
      COND_GE: o_true = !w_lt;
      COND_GT: o_true = !i_flags.zero && !w_lt;
      COND_LE: o_true = i_flags.zero || w_lt;
      COND_NV: o_true = 1'b0;
      default: o_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_reg.sv
// ALU status register with bus load/readback, condition evaluation and an optional
// LIFO save stack enabled by defining ALU_STATUS_STACK_EN.
module alu_status_reg
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  alu_status_t      alu_status,
  input  logic             status_ld,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_ld,
  input  logic             bus_oe,
  output wire  [WIDTH-1:0] bus_out,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  cond_e            cond,
  output logic             cond_true,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  alu_status_t r_flags;
  alu_status_t w_flags_nxt;
  alu_status_t w_pop_val;
  logic        w_do_pop;
  logic        w_unused_bus;

  assign w_unused_bus = ^bus_in[WIDTH-1:STATUS_BITS];

`ifdef ALU_STATUS_STACK_EN
  logic [SP_W-1:0]  r_sp;
  logic             r_err;
  alu_status_t      r_stack [STACK_DEPTH];
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_pop_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_err_set;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  // Simultaneous push and pop cancel each other entirely.
  assign w_do_push  = push && !pop && !w_full;
  assign w_do_pop   = pop && !push && !w_empty;
  assign w_err_set  = (push && !pop && w_full) || (pop && !push && w_empty);
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_pop_val  = r_stack[w_pop_idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_do_push)
        r_sp <= r_sp + SP_W'(1);
      else if (w_do_pop)
        r_sp <= r_sp - SP_W'(1);
      if (w_err_set)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
    end
  end

  // NOTE: stack storage is left out of reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_stack[w_push_idx] <= r_flags;
  end

  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign stack_err   = r_err;
`else
  logic w_unused_stack;

  assign w_unused_stack = push ^ pop ^ err_clr;
  assign w_do_pop       = 1'b0;
  assign w_pop_val      = '0;
  assign stack_empty    = 1'b1;
  assign stack_full     = 1'b1;
  assign stack_err      = 1'b0;
`endif

  always_comb begin
    w_flags_nxt = r_flags;
    if (w_do_pop)
      w_flags_nxt = w_pop_val;
    else if (bus_ld)
      w_flags_nxt = alu_status_t'(bus_in[STATUS_BITS-1:0]);
    else if (status_ld)
      w_flags_nxt = alu_status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_flags <= '0;
    else
      r_flags <= w_flags_nxt;
  end

  assign bus_out = bus_oe ? {{(WIDTH - STATUS_BITS){1'b0}}, r_flags} : {WIDTH{1'bz}};

  cond_eval u_cond_eval (
    .i_flags (r_flags),
    .i_cond  (cond),
    .o_true  (cond_true)
  );

endmodule

// File: tb/tb_alu_status_reg.sv
// Self-checking bench for alu_status_reg: directed scenarios plus randomized traffic
// compared every cycle against a flag/queue reference model.
module tb_alu_status_reg;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
`ifdef ALU_STATUS_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  alu_status_t      alu_status = '0;
  logic             status_ld = 1'b0;
  logic [WIDTH-1:0] bus_in = '0;
  logic             bus_ld = 1'b0;
  logic             bus_oe = 1'b0;
  wire  [WIDTH-1:0] bus_out;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             err_clr = 1'b0;
  cond_e            cond = COND_AL;
  logic             cond_true;
  logic             stack_empty;
  logic             stack_full;
  logic             stack_err;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [3:0] m_flags = '0;
  logic [3:0] m_stack[$];
  bit         m_err = 1'b0;

  alu_status_reg #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_status  (alu_status),
    .status_ld   (status_ld),
    .bus_in      (bus_in),
    .bus_ld      (bus_ld),
    .bus_oe      (bus_oe),
    .bus_out     (bus_out),
    .push        (push),
    .pop         (pop),
    .err_clr     (err_clr),
    .cond        (cond),
    .cond_true   (cond_true),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // bus_out with oe low must not carry data: released (z) or, in a 2-state simulator, 0.
  task automatic check_released(input string name);
    n_cmp++;
    if (!((bus_out === '0) || (bus_out === {WIDTH{1'bz}}))) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected released bus at %0t", name, bus_out, $time);
    end
  endtask

  function automatic bit model_cond(input logic [3:0] f, input int c);
    bit z, n, cy, v;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    case (c)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return n;
      4: return !n;
      5: return v;
      6: return !v;
      7: return cy;
      8: return !cy;
      9: return cy && !z;
      10: return !cy || z;
      11: return n != v;
      12: return n == v;
      13: return !z && (n == v);
      14: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] nf;
    bit popped, perr;
    nf = m_flags;
    popped = 1'b0;
    perr = 1'b0;
    if (STACK_EN && !(push && pop)) begin
      if (pop) begin
        if (m_stack.size() > 0) begin
          nf = m_stack.pop_back();
          popped = 1'b1;
        end else perr = 1'b1;
      end
      if (push) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
        else perr = 1'b1;
      end
    end
    if (!popped) begin
      if (bus_ld) nf = bus_in[3:0];
      else if (status_ld) nf = alu_status;
    end
    if (STACK_EN) begin
      if (err_clr) m_err = 1'b0;
      if (perr) m_err = 1'b1;
    end
    m_flags = nf;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_cond", WIDTH'(cond_true), WIDTH'(model_cond(m_flags, int'(cond))));
      check("cmp_empty", WIDTH'(stack_empty), WIDTH'(STACK_EN ? (m_stack.size() == 0) : 1'b1));
      check("cmp_full", WIDTH'(stack_full), WIDTH'(STACK_EN ? (m_stack.size() == DEPTH) : 1'b1));
      check("cmp_err", WIDTH'(stack_err), WIDTH'(m_err));
      if (bus_oe) check("cmp_bus", bus_out, WIDTH'(m_flags));
      else check_released("cmp_bus_z");
    end
  end

  // One clock edge: model follows the DUT, then controls return to idle.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #2;
    status_ld = 1'b0;
    bus_ld = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic ld(input logic [3:0] v);
    alu_status = alu_status_t'(v);
    status_ld = 1'b1;
    tick();
  endtask

  task automatic chk_cond(input string name, input cond_e c, input logic exp);
    cond = c;
    #1;
    check(name, WIDTH'(cond_true), WIDTH'(exp));
  endtask

  task automatic chk_flags(input string name, input logic [3:0] exp);
    bus_oe = 1'b1;
    #1;
    check(name, bus_out, WIDTH'(exp));
  endtask

  initial begin
    logic [3:0] saved;
    int sp_before;

    // 1: reset state
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk_flags("rst_bus", 4'h0);
    chk_cond("rst_al", COND_AL, 1'b1);
    chk_cond("rst_eq", COND_EQ, 1'b0);
    chk_cond("rst_ne", COND_NE, 1'b1);
    chk_cond("rst_nv", COND_NV, 1'b0);
    check("rst_empty", WIDTH'(stack_empty), WIDTH'(1));
    check("rst_err", WIDTH'(stack_err), WIDTH'(0));

    // 2: zero flag
    ld(4'b0001);
    chk_cond("z_eq", COND_EQ, 1'b1);
    chk_cond("z_le", COND_LE, 1'b1);
    chk_cond("z_gt", COND_GT, 1'b0);
    chk_cond("z_hi", COND_HI, 1'b0);

    // 3: signed and unsigned comparisons
    ld(4'b0010);
    chk_cond("n_lt", COND_LT, 1'b1);
    chk_cond("n_ge", COND_GE, 1'b0);
    ld(4'b1010);
    chk_cond("nv_ge", COND_GE, 1'b1);
    chk_cond("nv_lt", COND_LT, 1'b0);
    ld(4'b0100);
    chk_cond("c_hi", COND_HI, 1'b1);
    chk_cond("c_ls", COND_LS, 1'b0);

    // 4: bus load and readback
    bus_in = 32'hFFFF_FFFF;
    bus_ld = 1'b1;
    tick();
    chk_flags("bus_rd", 4'hF);
    bus_oe = 1'b0;
    #1;
    check_released("bus_hiz");

    // 5: stack fill, overflow, drain, underflow
    for (int i = 0; i < 4; i++) begin
      ld(4'(1 << i));
      push = 1'b1;
      tick();
    end
    check("push4_full", WIDTH'(stack_full), WIDTH'(1));
    check("push4_err", WIDTH'(stack_err), WIDTH'(0));
    push = 1'b1;
    tick();
    check("push5_err", WIDTH'(stack_err), WIDTH'(STACK_EN));
    check("push5_full", WIDTH'(stack_full), WIDTH'(1));
    for (int i = 3; i >= 0; i--) begin
      pop = 1'b1;
      tick();
      chk_flags("pop_val", STACK_EN ? 4'(1 << i) : 4'h8);
    end
    pop = 1'b1;
    tick();
    chk_flags("pop5_flags", STACK_EN ? 4'h1 : 4'h8);
    check("pop5_err", WIDTH'(stack_err), WIDTH'(STACK_EN));
    check("pop5_empty", WIDTH'(stack_empty), WIDTH'(1));
    err_clr = 1'b1;
    tick();
    check("err_clr", WIDTH'(stack_err), WIDTH'(0));

    // 6: same-edge interactions
    ld(4'h3);
    push = 1'b1;
    alu_status = alu_status_t'(4'hC);
    status_ld = 1'b1;
    tick();
    chk_flags("push_ld", 4'hC);
    pop = 1'b1;
    tick();
    chk_flags("pop_old", STACK_EN ? 4'h3 : 4'hC);
    ld(4'h6);
    push = 1'b1;
    tick();
    saved = bus_out[3:0];
    sp_before = m_stack.size();
    push = 1'b1;
    pop = 1'b1;
    tick();
    chk_flags("pp_flags", saved);
    check("pp_err", WIDTH'(stack_err), WIDTH'(0));
    check("pp_depth", WIDTH'(stack_empty), WIDTH'(STACK_EN ? (sp_before == 0) : 1'b1));

    // Asynchronous reset between edges
    ld(4'h5);
    pop = 1'b1;
    tick();
    pop = 1'b1;
    tick();
    rst = 1'b1;
    model_reset();
    chk_flags("arst_bus", 4'h0);
    check("arst_empty", WIDTH'(stack_empty), WIDTH'(1));
    check("arst_err", WIDTH'(stack_err), WIDTH'(0));
    tick();
    rst = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(63) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        alu_status = alu_status_t'(4'($urandom));
        bus_in = $urandom;
        status_ld = ($urandom_range(2) == 0);
        bus_ld = ($urandom_range(4) == 0);
        push = ($urandom_range(3) == 0);
        pop = ($urandom_range(3) == 0);
        err_clr = ($urandom_range(7) == 0);
        bus_oe = ($urandom_range(3) != 0);
        cond = cond_e'(4'($urandom));
        if (push && pop) begin
          status_ld = 1'b0;
          bus_ld = 1'b0;
        end
        tick();
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
